// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multi-cycle control unit
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        PAUSE,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_REG,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } iclass_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] HC_NONE    = 2'd0;
    localparam logic [1:0] HC_SYSTEM  = 2'd1;
    localparam logic [1:0] HC_ILLEGAL = 2'd2;
    localparam logic [1:0] HC_BUS     = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // ALU opcodes are {funct7[5], funct3} for register ops; BSEL passes operand B through
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SUB  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd13;
    localparam logic [3:0] ALU_BSEL = 4'd15;

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic breq,
                                          input logic brlt);
        logic cond;
        cond = funct3[2] ? brlt : breq;
        return funct3[0] ? ~cond : cond;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational instruction classifier and datapath select decode
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] inst,
    output iclass_t     iclass,
    output logic [3:0]  alu_sel,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  wb_sel,
    output logic [2:0]  dmem_size,
    output logic        br_unsigned,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b;
    logic       unused_inst_bits;

    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign f7b       = inst[30];
    assign dmem_size = funct3;
    assign legal     = (iclass != CLS_ILLEGAL);
    assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

    always_comb begin
        iclass      = CLS_ILLEGAL;
        alu_sel     = ALU_ADD;
        asel        = 1'b0;
        bsel        = 1'b1;
        wb_sel      = WB_ALU;
        br_unsigned = 1'b0;
        case (opcode)
            OP_REG: begin
                iclass  = CLS_REG;
                bsel    = 1'b0;
                alu_sel = {f7b, funct3};
            end
            OP_IMM: begin
                iclass  = CLS_IMM;
                // funct7[5] only selects SRAI; for other I-ops those bits are immediate
                alu_sel = {(funct3 == 3'b101) & f7b, funct3};
            end
            OP_LOAD: begin
                iclass = CLS_LOAD;
                wb_sel = WB_MEM;
            end
            OP_STORE: iclass = CLS_STORE;
            OP_BRANCH: begin
                if (funct3[2:1] != 2'b01) begin
                    iclass = CLS_BRANCH;
                end
                asel        = 1'b1;
                br_unsigned = funct3[1];
            end
            OP_LUI: begin
                iclass  = CLS_LUI;
                alu_sel = ALU_BSEL;
            end
            OP_AUIPC: begin
                iclass = CLS_AUIPC;
                asel   = 1'b1;
            end
            OP_JAL: begin
                iclass = CLS_JAL;
                asel   = 1'b1;
                wb_sel = WB_PC4;
            end
            OP_JALR: begin
                iclass = CLS_JALR;
                wb_sel = WB_PC4;
            end
            OP_SYSTEM: iclass = CLS_SYSTEM;
            default: iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with bus timeout, single-step and halt
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 15,
    parameter bit STEP_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst,
    input  logic             breq,
    input  logic             brlt,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             step_en,
    input  logic             step,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             asel,
    output logic             bsel,
    output logic [3:0]       alu_sel,
    output logic             br_unsigned,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [2:0]       dmem_size,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       wait_q;
    logic             step_mode_q;
    logic             pause_q;
    logic             retire;
    logic             waiting;

    iclass_t    dec_class;
    logic [3:0] dec_alu_sel;
    logic       dec_asel, dec_bsel, dec_br_unsigned, dec_legal;
    logic [1:0] dec_wb_sel;
    logic [2:0] dec_size;

    mc_decode u_decode (
        .inst        (inst),
        .iclass      (dec_class),
        .alu_sel     (dec_alu_sel),
        .asel        (dec_asel),
        .bsel        (dec_bsel),
        .wb_sel      (dec_wb_sel),
        .dmem_size   (dec_size),
        .br_unsigned (dec_br_unsigned),
        .legal       (dec_legal)
    );

    assign waiting = ((state_q == FETCH) && !imem_ack) || ((state_q == MEM) && !dmem_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            cause_q     <= HC_NONE;
            count_q     <= '0;
            wait_q      <= '0;
            step_mode_q <= STEP_DEFAULT;
            pause_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            wait_q      <= waiting ? wait_q + 8'd1 : 8'd0;
            step_mode_q <= step_en;
            // high from the second PAUSE cycle on, so a step on the entry cycle is ignored
            pause_q     <= (state_q == PAUSE);
            if (retire) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        retire      = 1'b0;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = WB_ALU;
        asel        = 1'b0;
        bsel        = 1'b0;
        alu_sel     = ALU_ADD;
        br_unsigned = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_size   = 3'd0;

        if (state_q == EXEC || state_q == MEM || state_q == WB) begin
            asel        = dec_asel;
            bsel        = dec_bsel;
            alu_sel     = dec_alu_sel;
            br_unsigned = dec_br_unsigned;
        end

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = HALT;
                    cause_d = HC_BUS;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (!dec_legal) begin
                    state_d = HALT;
                    cause_d = HC_ILLEGAL;
                end else begin
                    case (dec_class)
                        CLS_SYSTEM: begin
                            state_d = HALT;
                            cause_d = HC_SYSTEM;
                        end
                        CLS_BRANCH: begin
                            pc_we  = 1'b1;
                            pc_sel = branch_taken(inst[14:12], breq, brlt);
                            retire = 1'b1;
                        end
                        CLS_LOAD, CLS_STORE: state_d = MEM;
                        default: state_d = WB;
                    endcase
                end
            end
            MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = (dec_class == CLS_STORE);
                dmem_size = dec_size;
                if (dmem_ack) begin
                    if (dec_class == CLS_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = HALT;
                    cause_d = HC_BUS;
                end
            end
            WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                pc_sel = (dec_class == CLS_JAL) || (dec_class == CLS_JALR);
                wb_sel = dec_wb_sel;
                retire = 1'b1;
            end
            PAUSE: begin
                if (!step_mode_q || (step && pause_q)) begin
                    state_d = FETCH;
                end
            end
            default: state_d = HALT;
        endcase

        if (retire) begin
            state_d = step_mode_q ? PAUSE : FETCH;
        end

        // a reset cycle aborts any in-flight access without issuing enables
        if (reset) begin
            imem_req    = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_sel      = 1'b0;
            reg_we      = 1'b0;
            wb_sel      = WB_ALU;
            asel        = 1'b0;
            bsel        = 1'b0;
            alu_sel     = ALU_ADD;
            br_unsigned = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            dmem_size   = 3'd0;
        end
    end

    assign halted      = (state_q == HALT) && !reset;
    assign halt_cause  = reset ? HC_NONE : cause_q;
    assign instr_count = reset ? '0 : count_q;

endmodule
